guess_evaluator: RTL and testbench

Sits directly downstream of the letter-selection stage. On the selection stage's single-cycle submit pulse it latches the five-letter guess row and scores it against the secret target word using Wordle duplicate-letter rules. It produces a coloured row for the board store and tracks the guess count and the win/lose condition. Cell encoding matches the board: 7 bits per cell, [6:5] colour (grey=0, yellow=1, green=2, red=3), [4:0] letter (A=0..Z=25, blank=26).

---
 rtl/guess_evaluator_pkg.sv | 52 +++++
 rtl/guess_evaluator_yellow_match_finder.sv | 31 +++
 rtl/guess_evaluator.sv | 269 ++++++++++++++++++++++++++
 tb/tb_guess_evaluator.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_evaluator_pkg.sv
// Shared definitions for the guess evaluator: cell layout, colour codes,
// FSM state encoding and small row-packing helpers.
package guess_evaluator_pkg;

  localparam int CELL_W   = 7;
  localparam int WORD_LEN = 5;
  localparam int LETTER_W = 5;
  localparam int COLOUR_W = 2;

  localparam logic [COLOUR_W-1:0] COL_GREY   = 2'd0;
  localparam logic [COLOUR_W-1:0] COL_YELLOW = 2'd1;
  localparam logic [COLOUR_W-1:0] COL_GREEN  = 2'd2;
  localparam logic [COLOUR_W-1:0] COL_RED    = 2'd3;

  localparam logic [LETTER_W-1:0] LETTER_BLANK = 5'd26;
  localparam logic [LETTER_W-1:0] LETTER_MAX   = 5'd25;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_DONE   = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  // Letter i lives at [5i+4:5i], cell i at [7i+6:7i]; index 0 is leftmost.
  typedef logic [WORD_LEN-1:0][LETTER_W-1:0] letters_t;
  typedef logic [WORD_LEN-1:0][CELL_W-1:0]   row_t;

  function automatic logic [CELL_W-1:0] make_cell(input logic [COLOUR_W-1:0] colour,
                                                  input logic [LETTER_W-1:0] letter);
    return {colour, letter};
  endfunction

  function automatic row_t blank_row();
    row_t r;
    for (int i = 0; i < WORD_LEN; i++) begin
      r[i] = make_cell(COL_GREY, LETTER_BLANK);
    end
    return r;
  endfunction

  // Drops the colour field of every cell; incoming guess colours are ignored.
  function automatic letters_t row_letters(input row_t r);
    letters_t l;
    for (int i = 0; i < WORD_LEN; i++) begin
      l[i] = r[i][LETTER_W-1:0];
    end
    return l;
  endfunction

endpackage

// File: rtl/guess_evaluator_yellow_match_finder.sv
// Finds the lowest target position that holds the given letter and has not
// yet been claimed by a green or an earlier yellow.
module yellow_match_finder
  import guess_evaluator_pkg::*;
(
  input  logic [LETTER_W-1:0] letter,
  input  letters_t            target,
  input  logic [WORD_LEN-1:0] used_mask,
  output logic                found,
  output logic [WORD_LEN-1:0] match_onehot
);

  localparam logic [WORD_LEN-1:0] ONE = {{(WORD_LEN-1){1'b0}}, 1'b1};

  logic [WORD_LEN-1:0] free_match_s;

  // Mark every target position still carrying an unconsumed copy of the letter.
  always_comb begin
    free_match_s = {WORD_LEN{1'b0}};
    for (int j = 0; j < WORD_LEN; j++) begin
      free_match_s[j] = ~used_mask[j] & (target[j] == letter);
    end
  end

  // Isolate the lowest set bit so duplicates are consumed left to right.
  always_comb begin
    match_onehot = free_match_s & (~free_match_s + ONE);
    found        = |free_match_s;
  end

endmodule

// File: rtl/guess_evaluator.sv
// Scores a submitted five-letter row against the target word with Wordle
// duplicate-letter rules, one column per cycle, and tracks win/lose state.
module guess_evaluator
  import guess_evaluator_pkg::*;
#(
  parameter int MAX_ROWS = 6,
  parameter int ROW_W    = 3
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         submit,
  input  logic [WORD_LEN*CELL_W-1:0]   guess,
  input  logic [WORD_LEN*LETTER_W-1:0] target,
  output logic [WORD_LEN*CELL_W-1:0]   result,
  output logic                         result_valid,
  output logic                         invalid,
  output logic                         busy,
  output logic [ROW_W-1:0]             row_idx,
  output logic                         win,
  output logic                         lose
);

  localparam logic [ROW_W-1:0]    MAX_ROWS_W = ROW_W'(MAX_ROWS);
  localparam logic [ROW_W-1:0]    ROW_ONE    = {{(ROW_W-1){1'b0}}, 1'b1};
  localparam logic [WORD_LEN-1:0] COL_ONE    = {{(WORD_LEN-1){1'b0}}, 1'b1};
  localparam logic [2:0]          LAST_COL   = 3'(WORD_LEN - 1);

  // FSM state
  state_t state_r;
  state_t state_next_s;

  // Latched operands and scoring state
  letters_t            guess_lat_r,  guess_lat_n;
  letters_t            target_lat_r, target_lat_n;
  logic [WORD_LEN-1:0] green_mask_r, green_mask_n;
  logic [WORD_LEN-1:0] used_mask_r,  used_mask_n;
  logic [2:0]          col_r,        col_n;
  row_t                work_r,       work_n;

  // Registered outputs
  row_t             result_r,       result_n;
  logic             result_valid_r, result_valid_n;
  logic             invalid_r,      invalid_n;
  logic             busy_r,         busy_n;
  logic [ROW_W-1:0] row_idx_r,      row_idx_n;
  logic             win_r,          win_n;
  logic             lose_r,         lose_n;

  // Combinational helpers
  logic                any_bad_s;
  logic [WORD_LEN-1:0] green_s;
  row_t                red_row_s;
  logic [WORD_LEN-1:0] col_sel_s;
  logic [LETTER_W-1:0] cur_letter_s;
  logic                cur_green_s;
  logic                found_s;
  logic [WORD_LEN-1:0] onehot_s;
  logic [WORD_LEN-1:0] claim_s;
  logic [CELL_W-1:0]   cell_s;
  logic [ROW_W-1:0]    row_inc_s;

  yellow_match_finder u_finder (
    .letter       (cur_letter_s),
    .target       (target_lat_r),
    .used_mask    (used_mask_r),
    .found        (found_s),
    .match_onehot (onehot_s)
  );

  // Whole-row checks used by the GREEN pass: letter range, exact matches, red fill.
  always_comb begin
    any_bad_s = 1'b0;
    green_s   = {WORD_LEN{1'b0}};
    red_row_s = blank_row();
    for (int i = 0; i < WORD_LEN; i++) begin
      any_bad_s    = any_bad_s | (guess_lat_r[i] > LETTER_MAX);
      green_s[i]   = (guess_lat_r[i] == target_lat_r[i]);
      red_row_s[i] = make_cell(COL_RED, guess_lat_r[i]);
    end
  end

  // Select the column under evaluation in the YELLOW pass.
  always_comb begin
    col_sel_s    = COL_ONE << col_r;
    cur_letter_s = {LETTER_W{1'b0}};
    cur_green_s  = 1'b0;
    for (int i = 0; i < WORD_LEN; i++) begin
      cur_letter_s = cur_letter_s | ({LETTER_W{col_sel_s[i]}} & guess_lat_r[i]);
      cur_green_s  = cur_green_s | (col_sel_s[i] & green_mask_r[i]);
    end
  end

  // Colour the current column; a yellow claims the matched target position.
  always_comb begin
    claim_s = {WORD_LEN{1'b0}};
    cell_s  = make_cell(COL_GREY, cur_letter_s);
    if (cur_green_s) begin
      cell_s = make_cell(COL_GREEN, cur_letter_s);
    end else if (found_s) begin
      cell_s  = make_cell(COL_YELLOW, cur_letter_s);
      claim_s = onehot_s;
    end else begin
      cell_s = make_cell(COL_GREY, cur_letter_s);
    end
  end

  // Saturating guess counter increment.
  always_comb begin
    if (row_idx_r < MAX_ROWS_W) begin
      row_inc_s = row_idx_r + ROW_ONE;
    end else begin
      row_inc_s = row_idx_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; win/lose are already registered when DONE is reached.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (submit) begin
          state_next_s = ST_GREEN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_GREEN: begin
        if (any_bad_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (col_r == LAST_COL) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_YELLOW;
        end
      end
      ST_DONE: begin
        if (win_r || lose_r) begin
          state_next_s = ST_OVER;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_OVER: state_next_s = ST_OVER;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the datapath and all registered outputs.
  always_comb begin
    guess_lat_n  = guess_lat_r;
    target_lat_n = target_lat_r;
    green_mask_n = green_mask_r;
    used_mask_n  = used_mask_r;
    col_n        = col_r;
    work_n       = work_r;
    invalid_n    = invalid_r;

    case (state_r)
      ST_IDLE: begin
        if (submit) begin
          guess_lat_n  = row_letters(guess);
          target_lat_n = target;
          invalid_n    = 1'b0;
        end else begin
          invalid_n = invalid_r;
        end
      end
      ST_GREEN: begin
        if (any_bad_s) begin
          work_n    = red_row_s;
          invalid_n = 1'b1;
        end else begin
          green_mask_n = green_s;
          used_mask_n  = green_s;
          col_n        = 3'd0;
        end
      end
      ST_YELLOW: begin
        for (int i = 0; i < WORD_LEN; i++) begin
          work_n[i] = col_sel_s[i] ? cell_s : work_r[i];
        end
        used_mask_n = used_mask_r | claim_s;
        col_n       = col_r + 3'd1;
      end
      ST_DONE: col_n = col_r;
      ST_OVER: col_n = col_r;
      default: col_n = col_r;
    endcase

    result_n       = result_r;
    result_valid_n = 1'b0;
    row_idx_n      = row_idx_r;
    win_n          = win_r;
    lose_n         = lose_r;
    busy_n         = (state_next_s == ST_GREEN) || (state_next_s == ST_YELLOW) ||
                     (state_next_s == ST_DONE);

    // Publish the row together with the counters so they agree in the DONE cycle.
    if (state_next_s == ST_DONE) begin
      result_n       = work_n;
      result_valid_n = 1'b1;
      if (state_r == ST_YELLOW) begin
        row_idx_n = row_inc_s;
        win_n     = &green_mask_r;
        lose_n    = ~(&green_mask_r) & (row_inc_s == MAX_ROWS_W);
      end else begin
        row_idx_n = row_idx_r;
      end
    end else begin
      result_n = result_r;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      guess_lat_r    <= {(WORD_LEN*LETTER_W){1'b0}};
      target_lat_r   <= {(WORD_LEN*LETTER_W){1'b0}};
      green_mask_r   <= {WORD_LEN{1'b0}};
      used_mask_r    <= {WORD_LEN{1'b0}};
      col_r          <= 3'd0;
      work_r         <= blank_row();
      result_r       <= blank_row();
      result_valid_r <= 1'b0;
      invalid_r      <= 1'b0;
      busy_r         <= 1'b0;
      row_idx_r      <= {ROW_W{1'b0}};
      win_r          <= 1'b0;
      lose_r         <= 1'b0;
    end else begin
      guess_lat_r    <= guess_lat_n;
      target_lat_r   <= target_lat_n;
      green_mask_r   <= green_mask_n;
      used_mask_r    <= used_mask_n;
      col_r          <= col_n;
      work_r         <= work_n;
      result_r       <= result_n;
      result_valid_r <= result_valid_n;
      invalid_r      <= invalid_n;
      busy_r         <= busy_n;
      row_idx_r      <= row_idx_n;
      win_r          <= win_n;
      lose_r         <= lose_n;
    end
  end

  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign invalid      = invalid_r;
  assign busy         = busy_r;
  assign row_idx      = row_idx_r;
  assign win          = win_r;
  assign lose         = lose_r;

endmodule

// File: tb/tb_guess_evaluator.sv
// Scoreboard bench for guess_evaluator: stimulus pushes hand-computed
// expected rows, a negedge monitor pops and compares on result_valid.
module tb_guess_evaluator;

  logic        clk;
  logic        clr;
  logic        submit;
  logic [34:0] guess;
  logic [24:0] target;
  logic [34:0] result;
  logic        result_valid;
  logic        invalid;
  logic        busy;
  logic [2:0]  row_idx;
  logic        win;
  logic        lose;

  typedef struct {
    logic [34:0] res;
    logic        inv;
    logic [2:0]  row;
    logic        w;
    logic        l;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  guess_evaluator #(.MAX_ROWS(6), .ROW_W(3)) dut (
    .clk          (clk),
    .clr          (clr),
    .submit       (submit),
    .guess        (guess),
    .target       (target),
    .result       (result),
    .result_valid (result_valid),
    .invalid      (invalid),
    .busy         (busy),
    .row_idx      (row_idx),
    .win          (win),
    .lose         (lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] ltr(input logic [7:0] ch);
    logic [7:0] d;
    d = ch - 8'd65;
    return d[4:0];
  endfunction

  function automatic logic [24:0] tw(input logic [39:0] s);
    logic [24:0] r;
    for (int i = 0; i < 5; i++) r[5*i +: 5] = ltr(s[8*(4-i) +: 8]);
    return r;
  endfunction

  function automatic logic [34:0] gw(input logic [39:0] s, input logic [1:0] junk);
    logic [34:0] r;
    for (int i = 0; i < 5; i++) r[7*i +: 7] = {junk, ltr(s[8*(4-i) +: 8])};
    return r;
  endfunction

  function automatic logic [34:0] er(input logic [39:0] s, input logic [1:0] c0,
                                     input logic [1:0] c1, input logic [1:0] c2,
                                     input logic [1:0] c3, input logic [1:0] c4);
    logic [34:0]     r;
    logic [4:0][1:0] c;
    c = {c4, c3, c2, c1, c0};
    for (int i = 0; i < 5; i++) r[7*i +: 7] = {c[i], ltr(s[8*(4-i) +: 8])};
    return r;
  endfunction

  function automatic logic [34:0] blank();
    logic [34:0] r;
    for (int i = 0; i < 5; i++) r[7*i +: 7] = 7'h1A;
    return r;
  endfunction

  function automatic exp_t mk(input logic [34:0] r, input logic inv, input logic [2:0] row,
                              input logic w, input logic l, input int lat);
    exp_t e;
    e.res = r; e.inv = inv; e.row = row; e.w = w; e.l = l; e.due = lat;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: every result_valid must match the oldest expected row and its due cycle.
  always @(negedge clk) begin
    if (clr === 1'b0 && result_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got result_valid=1 at cycle %0d expected none", cyc);
      end else begin
        m_e = q.pop_front();
        chk("latency", 64'(cyc), 64'(m_e.due));
        chk("result", 64'(result), 64'(m_e.res));
        chk("invalid", 64'(invalid), 64'(m_e.inv));
        chk("row_idx", 64'(row_idx), 64'(m_e.row));
        chk("win", 64'(win), 64'(m_e.w));
        chk("lose", 64'(lose), 64'(m_e.l));
        chk("busy_in_done", 64'(busy), 64'd1);
      end
    end
  end

  task automatic do_submit(input logic [34:0] g, input logic [24:0] t,
                           input bit push, input exp_t e);
    exp_t x;
    @(negedge clk);
    guess  = g;
    target = t;
    submit = 1'b1;
    if (push) begin
      x     = e;
      x.due = cyc + e.due;
      q.push_back(x);
    end
    @(negedge clk);
    submit = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy !== 1'b0 || q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy=%b pending=%0d expected idle", name, busy, q.size());
      q.delete();
    end
  endtask

  task automatic check_reset(input string name);
    chk({name, "_result"}, 64'(result), 64'(blank()));
    chk({name, "_valid"}, 64'(result_valid), 64'd0);
    chk({name, "_invalid"}, 64'(invalid), 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_row"}, 64'(row_idx), 64'd0);
    chk({name, "_win"}, 64'(win), 64'd0);
    chk({name, "_lose"}, 64'(lose), 64'd0);
  endtask

  task automatic apply_clr(input string name);
    @(negedge clk);
    clr = 1'b1;
    #1;
    check_reset(name);
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic idle_over(input string name);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk({name, "_busy"}, 64'(busy), 64'd0);
    end
  endtask

  logic [34:0] bad_g;
  logic [34:0] bad_r;
  exp_t        none;

  initial begin
    clr    = 1'b1;
    submit = 1'b0;
    guess  = 35'd0;
    target = 25'd0;
    none   = mk(35'd0, 1'b0, 3'd0, 1'b0, 1'b0, 0);
    @(negedge clk);
    check_reset("por");
    @(negedge clk);
    clr = 1'b0;

    // Exact hit: all green, win, then OVER ignores submits.
    do_submit(gw("CRANE", 2'd0), tw("CRANE"), 1'b1,
              mk(er("CRANE", 2'd2, 2'd2, 2'd2, 2'd2, 2'd2), 1'b0, 3'd1, 1'b1, 1'b0, 7));
    wait_idle("win");
    do_submit(gw("EERIE", 2'd0), tw("CRANE"), 1'b0, none);
    idle_over("over_win");
    chk("over_hold_result", 64'(result), 64'(er("CRANE", 2'd2, 2'd2, 2'd2, 2'd2, 2'd2)));
    chk("over_hold_win", 64'(win), 64'd1);
    apply_clr("clr1");

    // Green consumes the only E; junk colour bits on the guess are ignored.
    do_submit(gw("EERIE", 2'd3), tw("CRANE"), 1'b1,
              mk(er("EERIE", 2'd0, 2'd0, 2'd1, 2'd0, 2'd2), 1'b0, 3'd1, 1'b0, 1'b0, 7));
    wait_idle("eerie");

    // Lowest-free-index matching of duplicate B.
    do_submit(gw("BABES", 2'd0), tw("ABBEY"), 1'b1,
              mk(er("BABES", 2'd1, 2'd1, 2'd2, 2'd2, 2'd0), 1'b0, 3'd2, 1'b0, 1'b0, 7));
    wait_idle("babes");

    // Blank letter in cell 2: all red, 2-cycle latency, count unchanged.
    bad_g = gw("CRANE", 2'd0);
    bad_g[14 +: 5] = 5'd26;
    bad_r = er("CRANE", 2'd3, 2'd3, 2'd3, 2'd3, 2'd3);
    bad_r[14 +: 5] = 5'd26;
    do_submit(bad_g, tw("CRANE"), 1'b1, mk(bad_r, 1'b1, 3'd2, 1'b0, 1'b0, 2));
    wait_idle("invalid");
    chk("invalid_held", 64'(invalid), 64'd1);

    do_submit(gw("SLOTH", 2'd0), tw("CRANE"), 1'b1,
              mk(er("SLOTH", 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 1'b0, 3'd3, 1'b0, 1'b0, 7));
    chk("invalid_cleared", 64'(invalid), 64'd0);
    wait_idle("sloth");

    do_submit(gw("DUMPY", 2'd0), tw("CRANE"), 1'b1,
              mk(er("DUMPY", 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 1'b0, 3'd4, 1'b0, 1'b0, 7));
    wait_idle("dumpy");

    // Second pulse while busy must be dropped.
    do_submit(gw("TOILS", 2'd0), tw("CRANE"), 1'b1,
              mk(er("TOILS", 2'd0, 2'd0, 2'd0, 2'd0, 2'd0), 1'b0, 3'd5, 1'b0, 1'b0, 7));
    do_submit(gw("CRANE", 2'd0), tw("CRANE"), 1'b0, none);
    wait_idle("toils");

    // Sixth valid row without a win: lose.
    do_submit(gw("BLOCK", 2'd0), tw("CRANE"), 1'b1,
              mk(er("BLOCK", 2'd0, 2'd0, 2'd0, 2'd1, 2'd0), 1'b0, 3'd6, 1'b0, 1'b1, 7));
    wait_idle("block");
    do_submit(gw("CRANE", 2'd0), tw("CRANE"), 1'b0, none);
    idle_over("over_lose");
    chk("over_lose_row", 64'(row_idx), 64'd6);
    chk("over_lose_flag", 64'(lose), 64'd1);
    apply_clr("clr2");

    // Reset in the third YELLOW cycle aborts with no result.
    do_submit(gw("BABES", 2'd0), tw("ABBEY"), 1'b0, none);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    #1;
    check_reset("abort");
    @(negedge clk);
    clr = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);

    do_submit(gw("BABES", 2'd0), tw("ABBEY"), 1'b1,
              mk(er("BABES", 2'd1, 2'd1, 2'd2, 2'd2, 2'd0), 1'b0, 3'd1, 1'b0, 1'b0, 7));
    wait_idle("after_abort");
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
